// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Main control FSM of the multi-cycle MIPS CPU. Each instruction is walked
// through fetch, decode, execute, memory and writeback. The FSM drives the
// datapath enables/selects and the ALUOP/Function pair that the ALU
// controller decodes.
//
// Ports
//   clk, reset_n         : rising-edge clock, asynchronous active-low reset
//   Opcode, Funct        : IR[31:26] and IR[5:0], sampled in DECODE only
//   MemReady             : memory finishes the current access this cycle
//   Zero                 : ALU zero flag (branch decision)
//   ALUOP, Function      : to the ALU controller (default 08/20 = add)
//   PCWrite .. ALUSrcA   : datapath enables and 1-bit selects
//   ALUSrcB              : 0 B, 1 const 4, 2 sign-ext imm, 3 imm << 2
//   PCSource             : 0 ALU result, 1 ALUOut, 2 jump target
//   Illegal              : one-cycle pulse in DECODE for unsupported opcodes
//   State                : current state, for debug
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  input  logic       Zero,
  output logic [5:0] ALUOP,
  output logic [5:0] Function,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU controller code pairs: "add" for address/PC arithmetic, "sub" for
  // the branch compare.
  localparam logic [5:0] ALUOP_ADD = 6'h08;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] ALUOP_SUB = 6'h04;

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RESET;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    ALUOP    = ALUOP_ADD;
    Function = FUNC_ADD;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    PCSource = 2'd0;
    Illegal  = 1'b0;

    case (state_q)
      S_RESET: begin
        ALUOP    = 6'h00;
        Function = 6'h00;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        // IR load and PC+4 commit happen in the cycle memory delivers.
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        ALUSrcB  = 2'd3;
        opcode_d = Opcode;
        funct_d  = Funct;
        case (Opcode)
          OP_RTYPE:                          state_d = S_REXEC;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOP   = opcode_q;
        state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_REXEC: begin
        ALUSrcA  = 1'b1;
        ALUOP    = 6'h00;
        Function = funct_q;
        state_d  = S_RWB;
      end
      S_RWB: begin
        // ALU code is held so the controller output stays stable through
        // the register write.
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        ALUOP    = 6'h00;
        Function = funct_q;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOP   = opcode_q;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        ALUSrcB  = 2'd2;
        ALUOP    = opcode_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOP    = ALUOP_SUB;
        PCSource = 2'd1;
        PCWrite  = ((opcode_q == OP_BEQ) &&  Zero) ||
                   ((opcode_q == OP_BNE) && !Zero);
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        state_d  = S_FETCH;
      end
      default: begin
        // Encodings 13..15 are never entered normally; recover via RESET.
        ALUOP    = 6'h00;
        Function = 6'h00;
        state_d  = S_RESET;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       MemReady;
  logic       Zero;
  logic [5:0] ALUOP;
  logic [5:0] Function;
  logic       PCWrite, IRWrite, MemRead, MemWrite, IorD;
  logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic       Illegal;
  logic [3:0] State;

  mips_multicycle_control dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Opcode   (Opcode),
    .Funct    (Funct),
    .MemReady (MemReady),
    .Zero     (Zero),
    .ALUOP    (ALUOP),
    .Function (Function),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSource (PCSource),
    .Illegal  (Illegal),
    .State    (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] aluop;
    logic [5:0] func;
    logic       pcw, irw, mrd, mwr, iord, rw, rdst, m2r, asa;
    logic [1:0] asb, pcs;
    logic       ill;
  } outs_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_valid;
  logic [3:0] exp_st;
  logic [5:0] m_op, m_fn;
  outs_t      snap [0:15];
  outs_t      cmp_exp, cmp_act;
  logic [63:0] seq;
  int         ill_cnt, wr_cnt;

  logic [5:0] bops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
  logic       bz   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       bpc  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Output table per state number, straight from the state descriptions.
  function automatic outs_t exp_out(input logic [3:0] st, input logic [5:0] lop,
                                    input logic [5:0] lfn, input logic [5:0] cop,
                                    input logic mr, input logic z);
    outs_t o;
    o = '0;
    o.st = st;
    if (st != 4'd0) begin
      o.aluop = 6'h08;
      o.func  = 6'h20;
    end
    case (st)
      4'd1: begin
        o.mrd = 1'b1; o.asb = 2'd1;
        if (mr) begin o.irw = 1'b1; o.pcw = 1'b1; end
      end
      4'd2: begin
        o.asb = 2'd3;
        if (!(cop inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
                          6'h0D, 6'h23, 6'h2B})) o.ill = 1'b1;
      end
      4'd3:  begin o.asa = 1'b1; o.asb = 2'd2; o.aluop = lop; end
      4'd4:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      4'd5:  begin o.rw = 1'b1; o.m2r = 1'b1; end
      4'd6:  begin o.mwr = 1'b1; o.iord = 1'b1; end
      4'd7:  begin o.asa = 1'b1; o.aluop = 6'h00; o.func = lfn; end
      4'd8:  begin o.rw = 1'b1; o.rdst = 1'b1; o.aluop = 6'h00; o.func = lfn; end
      4'd9:  begin o.asa = 1'b1; o.asb = 2'd2; o.aluop = lop; end
      4'd10: begin o.rw = 1'b1; o.asb = 2'd2; o.aluop = lop; end
      4'd11: begin
        o.asa = 1'b1; o.aluop = 6'h04; o.pcs = 2'd1;
        o.pcw = ((lop == 6'h04) && z) || ((lop == 6'h05) && !z);
      end
      4'd12: begin o.pcw = 1'b1; o.pcs = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t dut_vec();
    outs_t o;
    o.st = State; o.aluop = ALUOP; o.func = Function;
    o.pcw = PCWrite; o.irw = IRWrite; o.mrd = MemRead; o.mwr = MemWrite;
    o.iord = IorD; o.rw = RegWrite; o.rdst = RegDst; o.m2r = MemtoReg;
    o.asa = ALUSrcA; o.asb = ALUSrcB; o.pcs = PCSource; o.ill = Illegal;
    return o;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      cmp_exp = exp_out(exp_st, m_op, m_fn, Opcode, MemReady, Zero);
      cmp_act = dut_vec();
      n_checks++;
      if (cmp_act !== cmp_exp) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t state=%0d: actual=%h required=%h",
                 $time, exp_st, cmp_act, cmp_exp);
      end else begin
        $display("cycle t=%0t state=%0d outputs=%h ok", $time, exp_st, cmp_act);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs after the edge, let the compare process
  // check at the falling edge, then record a snapshot.
  task automatic cyc(input int st, input logic rst, input logic mr,
                     input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(posedge clk);
    #1;
    reset_n  = rst;
    MemReady = mr;
    Opcode   = op;
    Funct    = fn;
    Zero     = z;
    exp_st   = st[3:0];
    exp_valid = 1'b1;
    @(negedge clk);
    #1;
    snap[st[3:0]] = dut_vec();
    seq = {seq[59:0], State};
    if (Illegal) ill_cnt++;
    if (RegWrite || MemWrite) wr_cnt++;
  endtask

  // Path through the FSM derived from the instruction class.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic z, input logic [5:0] jop);
    for (int i = 0; i < fw; i++) cyc(1, 1'b1, 1'b0, op, fn, z);
    cyc(1, 1'b1, 1'b1, op, fn, z);
    cyc(2, 1'b1, 1'b0, op, fn, z);
    m_op = op;
    m_fn = fn;
    case (op)
      6'h00: begin
        cyc(7, 1'b1, 1'b0, jop, ~fn, z);
        cyc(8, 1'b1, 1'b0, jop, ~fn, z);
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        cyc(9,  1'b1, 1'b0, jop, ~fn, z);
        cyc(10, 1'b1, 1'b0, jop, ~fn, z);
      end
      6'h23: begin
        cyc(3, 1'b1, 1'b0, jop, ~fn, z);
        for (int i = 0; i < mw; i++) cyc(4, 1'b1, 1'b0, jop, ~fn, z);
        cyc(4, 1'b1, 1'b1, jop, ~fn, z);
        cyc(5, 1'b1, 1'b0, jop, ~fn, z);
      end
      6'h2B: begin
        cyc(3, 1'b1, 1'b0, jop, ~fn, z);
        for (int i = 0; i < mw; i++) cyc(6, 1'b1, 1'b0, jop, ~fn, z);
        cyc(6, 1'b1, 1'b1, jop, ~fn, z);
      end
      6'h04, 6'h05: cyc(11, 1'b1, 1'b0, jop, ~fn, z);
      6'h02:        cyc(12, 1'b1, 1'b0, jop, ~fn, z);
      default: ;
    endcase
  endtask

  initial begin
    reset_n = 1'b0; MemReady = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0;
    exp_valid = 1'b0; exp_st = '0; m_op = '0; m_fn = '0;
    seq = '0; ill_cnt = 0; wr_cnt = 0;

    // Reset held, then R-type add.
    cyc(0, 1'b0, 1'b1, 6'h00, 6'h20, 1'b0);
    cyc(0, 1'b0, 1'b1, 6'h00, 6'h20, 1'b0);
    chk("reset_state", State, 4'd0);
    chk("reset_aluop", ALUOP, 6'h00);
    chk("reset_function", Function, 6'h00);
    seq = '0;
    cyc(0, 1'b1, 1'b1, 6'h00, 6'h20, 1'b0);
    run_instr(6'h00, 6'h20, 0, 0, 1'b0, 6'h2B);
    chk("rtype_seq", seq[19:0], 20'h01278);
    chk("rexec_aluop", snap[7].aluop, 6'h00);
    chk("rexec_function", snap[7].func, 6'h20);
    chk("rwb_regwrite", snap[8].rw, 1'b1);
    chk("rwb_regdst", snap[8].rdst, 1'b1);

    // lw with two MEMRD wait cycles.
    seq = '0;
    run_instr(6'h23, 6'h00, 0, 2, 1'b0, 6'h00);
    chk("lw_seq", seq[27:0], 28'h1234445);
    chk("memrd_memread", snap[4].mrd, 1'b1);
    chk("memrd_iord", snap[4].iord, 1'b1);
    chk("memwb_regwrite", snap[5].rw, 1'b1);
    chk("memwb_memtoreg", snap[5].m2r, 1'b1);

    // beq/bne against both Zero values.
    for (int k = 0; k < 4; k++) begin
      seq = '0;
      run_instr(bops[k], 6'h00, 0, 0, bz[k], 6'h00);
      chk("branch_seq", seq[11:0], 12'h12B);
      chk("branch_pcwrite", snap[11].pcw, bpc[k]);
      chk("branch_aluop", snap[11].aluop, 6'h04);
    end

    // ori with one fetch wait; Opcode switched to addi after DECODE.
    seq = '0;
    run_instr(6'h0D, 6'h11, 1, 0, 1'b0, 6'h08);
    chk("imm_seq", seq[19:0], 20'h1129A);
    chk("iexec_aluop", snap[9].aluop, 6'h0D);
    chk("iexec_alusrcb", snap[9].asb, 2'd2);
    chk("iwb_aluop", snap[10].aluop, 6'h0D);
    chk("iwb_alusrcb", snap[10].asb, 2'd2);

    // Illegal opcode, followed by a jump.
    seq = '0; ill_cnt = 0; wr_cnt = 0;
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, 6'h00);
    chk("illegal_seq", seq[7:0], 8'h12);
    chk("illegal_pulses", ill_cnt, 1);
    chk("illegal_no_write", wr_cnt, 0);
    seq = '0;
    run_instr(6'h02, 6'h00, 0, 0, 1'b0, 6'h00);
    chk("jump_seq", seq[11:0], 12'h12C);

    // sw with no waits.
    seq = '0;
    run_instr(6'h2B, 6'h00, 0, 0, 1'b0, 6'h00);
    chk("sw_seq", seq[15:0], 16'h1236);

    // Asynchronous reset during a MEMWR wait.
    cyc(1, 1'b1, 1'b1, 6'h2B, 6'h00, 1'b0);
    cyc(2, 1'b1, 1'b0, 6'h2B, 6'h00, 1'b0);
    m_op = 6'h2B;
    cyc(3, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0);
    cyc(6, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0);
    chk("memwr_wait_memwrite", MemWrite, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_state", State, 4'd0);
    chk("async_reset_memwrite", MemWrite, 1'b0);
    chk("async_reset_iord", IorD, 1'b0);
    cyc(0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0);
    seq = '0;
    cyc(0, 1'b1, 1'b1, 6'h00, 6'h20, 1'b0);
    run_instr(6'h00, 6'h22, 0, 0, 1'b0, 6'h00);
    chk("post_reset_seq", seq[19:0], 20'h01278);

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle MIPS main control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables. It is the producer side of the ALU controller interface: it generates the `ALUOP`/`Function` pair that the ALU controller decodes into `ALU_Control`. It sits between the instruction register and the datapath of the multi-cycle CPU.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `Opcode` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `MemReady` in 1: memory completes the current read/write this cycle.
- `Zero` in 1: ALU zero flag.
- `ALUOP` out 6: ALU controller opcode input.
- `Function` out 6: ALU controller funct input.
- `PCWrite` out 1, `IRWrite` out 1, `MemRead` out 1, `MemWrite` out 1, `IorD` out 1, `RegWrite` out 1, `RegDst` out 1, `MemtoReg` out 1, `ALUSrcA` out 1: datapath enables and selects.
- `ALUSrcB` out 2: 0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate << 2.
- `PCSource` out 2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `Illegal` out 1: one-cycle pulse on an unsupported opcode.
- `State` out 4: current state, for debug.

## Operation
- States: RESET(0), FETCH(1), DECODE(2), MEMADR(3), MEMRD(4), MEMWB(5), MEMWR(6), REXEC(7), RWB(8), IEXEC(9), IWB(10), BRANCH(11), JUMP(12).
- Default output value: every output not listed for a state is 0, with `ALUOP` = 6'h08 and `Function` = 6'h20 (add).
- RESET: all outputs 0, `ALUOP` = 0, `Function` = 0. Unconditionally goes to FETCH.
- FETCH: `MemRead` = 1, `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 1, `PCSource` = 0.
  - While `MemReady` = 0, stay in FETCH with `IRWrite` = `PCWrite` = 0.
  - When `MemReady` = 1, `IRWrite` = `PCWrite` = 1 in the same cycle, then go to DECODE.
- DECODE: `ALUSrcA` = 0, `ALUSrcB` = 3 (branch target). Capture `Opcode`/`Funct` into internal registers. Next state by opcode:
  - 0x00 -> REXEC
  - 0x08, 0x0A, 0x0C, 0x0D -> IEXEC
  - 0x23, 0x2B -> MEMADR
  - 0x04, 0x05 -> BRANCH
  - 0x02 -> JUMP
  - any other opcode -> FETCH with `Illegal` = 1
- MEMADR: `ALUSrcA` = 1, `ALUSrcB` = 2, `ALUOP` = latched opcode. Goes to MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: `MemRead` = 1, `IorD` = 1. Holds until `MemReady`, then goes to MEMWB.
- MEMWB: `RegWrite` = 1, `MemtoReg` = 1, `RegDst` = 0. Goes to FETCH.
- MEMWR: `MemWrite` = 1, `IorD` = 1. Holds until `MemReady`, then goes to FETCH.
- REXEC: `ALUSrcA` = 1, `ALUSrcB` = 0, `ALUOP` = 0x00, `Function` = latched funct. Goes to RWB.
- RWB: `RegWrite` = 1, `RegDst` = 1, `MemtoReg` = 0. `ALUOP`/`Function` hold their REXEC values. Goes to FETCH.
- IEXEC: `ALUSrcA` = 1, `ALUSrcB` = 2, `ALUOP` = latched opcode. Goes to IWB.
- IWB: `RegWrite` = 1, `RegDst` = 0, `ALUOP` holds. Goes to FETCH.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 0, `ALUOP` = 0x04 (subtract), `PCSource` = 1.
  - `PCWrite` = (beq & `Zero`) | (bne & ~`Zero`).
  - Goes to FETCH.
- JUMP: `PCWrite` = 1, `PCSource` = 2. Goes to FETCH.
- Unreachable encodings 13–15 go to RESET on the next edge.

## Timing
- The state register updates on `clk` rising edge. Outputs are decoded combinationally from the state register and the latched opcode/funct.
- `PCWrite` and `IRWrite` additionally depend combinationally on `MemReady` (FETCH) or `Zero` (BRANCH).
- Reset:
  - `reset_n` low forces RESET immediately, asynchronously, including mid-instruction or mid-memory-wait.
  - All outputs are 0 while `reset_n` is low.
  - The first FETCH occurs one cycle after the first rising edge with `reset_n` high.
- Latency with zero memory wait, counted in cycles from FETCH entry to the next FETCH entry:
  - R-type: 4
  - immediate ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j: 3
- Each wait cycle (`MemReady` = 0) adds one cycle, in FETCH/MEMRD/MEMWR only.
- `MemReady` is ignored in all other states.
- `Opcode`/`Funct` are sampled only in DECODE; changes after DECODE have no effect on the instruction in flight.

## Test plan
- Reset, then R-type add: release `reset_n`, `MemReady` = 1, `Opcode` = 0, `Funct` = 0x20.
  - Required: `State` goes 0,1,2,7,8,1.
  - In REXEC: `ALUOP` = 0, `Function` = 0x20.
  - In RWB: `RegWrite` = 1, `RegDst` = 1.
- lw with memory waits: `Opcode` = 0x23, `MemReady` low for 2 cycles in MEMRD.
  - Required: states 1,2,3,4,4,4,5,1.
  - `MemRead`/`IorD` = 1 throughout MEMRD.
  - In MEMWB: `RegWrite` = `MemtoReg` = 1.
- Branch decision: beq with `Zero` = 1 -> `PCWrite` = 1 in BRANCH; beq with `Zero` = 0 -> `PCWrite` = 0; bne inverts both results. `ALUOP` = 0x04 in all four runs.
- Immediate ops: `Opcode` = 0x0D.
  - In IEXEC/IWB: `ALUOP` = 0x0D, `ALUSrcB` = 2.
  - Changing `Opcode` to 0x08 during IEXEC leaves `ALUOP` = 0x0D.
- Illegal opcode: `Opcode` = 0x3F.
  - Required: `Illegal` = 1 for exactly one cycle in DECODE, then `State` = 1.
  - No `RegWrite` or `MemWrite` is asserted.
- Asynchronous reset mid-operation: assert `reset_n` low during a MEMWR wait.
  - Required: `State` = 0 and `MemWrite` = 0 before the next clock edge.
  - After release: FETCH after one cycle.
